mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, SHALL set the SRAM access cycles per transaction (legal range 1..15).
REQ-002 Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch-stage read request; held until if_ready.
- if_addr  in  32  fetch address.
- if_flush  in  1  discard an in-flight fetch result.
- if_rdata  out  32  fetched instruction.
- if_ready  out  1  one-cycle fetch completion pulse.
- mem_req  in  1  memory-stage request; held until mem_ready.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  32  data address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data.
- mem_ready  out  1  one-cycle data completion pulse.
- sram_en  out  1  SRAM access active.
- sram_we  out  1  SRAM write strobe.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid in the last access cycle.
- freeze  out  1  pipeline stall to the stage registers.

Function
REQ-003 FSM states SHALL be IDLE, IF_ACC and MEM_ACC.
REQ-004 In IDLE, an unmasked request SHALL be granted at the next edge. A request is unmasked when its ready output is low.
REQ-005 If both requests are unmasked, the port not granted last SHALL win; after reset, last-grant SHALL be IF, so MEM wins the first tie.
REQ-006 At grant, the arbiter SHALL register the address, we and wdata, load the wait counter with WAIT_CYCLES-1, and record last-grant.
REQ-007 In IF_ACC and MEM_ACC, sram_en SHALL be 1 and sram_addr/sram_wdata SHALL be the registered values for exactly WAIT_CYCLES cycles. sram_we SHALL be 1 only in MEM_ACC with a registered we of 1.
REQ-008 The counter SHALL decrement each access cycle. At count 0 the next edge SHALL:
- capture sram_rdata into the granted port's rdata register (reads only; writes leave mem_rdata unchanged);
- pulse that port's ready for one cycle;
- return the FSM to IDLE.
REQ-009 Latency: request high in cycle t with FSM in IDLE -> access in cycles t+1..t+WAIT_CYCLES -> ready in cycle t+WAIT_CYCLES+1.
REQ-010 if_rdata and mem_rdata SHALL hold their value until the next read completion on the same port.
REQ-011 A port's req SHALL be ignored in its own ready cycle, so a held request is never re-granted. The other port MAY be granted in that cycle.
REQ-012 freeze SHALL be combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready).
REQ-013 if_flush high in any IF_ACC cycle SHALL suppress the resulting if_ready pulse and leave if_rdata unchanged. The SRAM access SHALL still run its full length.
REQ-014 if_flush in IDLE or MEM_ACC SHALL have no effect. There SHALL be no flush for MEM accesses; a started write always completes.
REQ-015 Requests dropped mid-access SHALL NOT abort the access; the ready pulse is still issued.

Reset
REQ-016 While rst=0, the FSM SHALL be IDLE and the counter 0; last-grant, sram_*, if_ready, mem_ready, if_rdata and mem_rdata SHALL be 0; a flush-pending flag SHALL be 0.
REQ-017 Reset asserted mid-access SHALL abort the access immediately with no ready pulse. The first grant SHALL occur at the first edge after rst returns to 1.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, IF_ACC=2'd1, MEM_ACC=2'd2), the WAIT_CYCLES default and the counter width (4).
REQ-019 The countdown SHALL be a sub-module mem_wait_counter with load, decrement and zero-flag behaviour; all other logic SHALL stay in mem_port_arbiter.

Verification
REQ-020 The bench SHALL cover these scenarios, all with WAIT_CYCLES=4:
- V1: if_req=1, if_addr=0x100 at cycle 0; sram_rdata=0xE3A01005 -> sram_en=1 in cycles 1-4, if_ready=1 in cycle 5 with if_rdata=0xE3A01005, freeze=1 in cycles 0-4.
- V2: if_req and mem_req (read 0x400) both rise at cycle 0 -> MEM served in cycles 1-4, mem_ready in cycle 5, IF granted at the cycle 5 edge, if_ready in cycle 10.
- V3: mem write 0x200 <- 0xDEADBEEF -> sram_we=1 in cycles 1-4 only, mem_ready in cycle 5, mem_rdata unchanged.
- V4: if_flush=1 in cycle 2 of an IF access -> no if_ready, if_rdata unchanged, FSM returns to IDLE after cycle 4.
- V5: rst=0 in cycle 3 of a MEM access -> all outputs 0 immediately; after release, a new if_req completes with normal 4+1 latency.
- V6: both ports continuously requesting -> grants alternate MEM, IF, MEM, IF, each completion 5 cycles apart.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   - arb_state_e : arbiter FSM encoding (idle, fetch access, data access)
//   - cnt_t       : wait-counter type
//   - wait_load() : counter preload for a given access length
package mem_arb_pkg;

  localparam int unsigned WaitCyclesDefault = 4;
  localparam int unsigned CntW              = 4;

  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfAcc  = 2'd1,
    StMemAcc = 2'd2
  } arb_state_e;

  // Counter counts down to zero, so an N-cycle access preloads N-1.
  function automatic cnt_t wait_load(input int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, SRAM port and freeze signals.
//   master : pipeline/SRAM side (drives requests and sram_rdata)
//   slave  : arbiter side (drives completions, SRAM controls and freeze)
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        freeze;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr, sram_wdata,
           freeze
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr, sram_wdata,
           freeze
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Access-length countdown for the arbiter.
//   clk_i, rst_ni : clock, async active-low reset (count -> 0)
//   load_i        : load load_val_i (has priority over dec_i)
//   dec_i         : decrement by one, saturating at zero
//   zero_o        : count is zero
module mem_wait_counter
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  logic dec_i,
  output logic zero_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle SRAM between the fetch (IF) and memory (MEM) stages.
//   clk, rst : clock, async active-low reset
//   bus_io   : slave side of mem_port_arbiter_if
//              if_*   : fetch read port, one-cycle if_ready pulse, if_flush drops a result
//              mem_*  : data read/write port, one-cycle mem_ready pulse
//              sram_* : registered SRAM controls, active for WAIT_CYCLES cycles per access
//              freeze : combinational stall while any request is outstanding
// Ties go to the port not granted last; a port is masked during its own ready cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus_io
);

  arb_state_e  state_q;
  logic        last_mem_q;   // 1 = MEM was granted last
  logic        flush_pend_q;
  logic        sram_en_q;
  logic        sram_we_q;
  logic [31:0] sram_addr_q;
  logic [31:0] sram_wdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;

  logic if_live, mem_live, pick_mem, pick_if;
  logic cnt_load, cnt_dec, cnt_zero;

  always_comb begin
    // A port's own ready cycle masks it so a still-held request is not re-granted.
    if_live  = bus_io.if_req  & ~if_ready_q;
    mem_live = bus_io.mem_req & ~mem_ready_q;
    pick_mem = mem_live & (~if_live | ~last_mem_q);
    pick_if  = if_live & ~pick_mem;
    cnt_load = (state_q == StIdle) & (pick_mem | pick_if);
    cnt_dec  = (state_q != StIdle) & ~cnt_zero;
  end

  mem_wait_counter u_wait_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (wait_load(WAIT_CYCLES)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_mem_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_mem) begin
            state_q      <= StMemAcc;
            last_mem_q   <= 1'b1;
            sram_en_q    <= 1'b1;
            sram_we_q    <= bus_io.mem_we;
            sram_addr_q  <= bus_io.mem_addr;
            sram_wdata_q <= bus_io.mem_wdata;
          end else if (pick_if) begin
            state_q      <= StIfAcc;
            last_mem_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            sram_en_q    <= 1'b1;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= bus_io.if_addr;
            sram_wdata_q <= '0;
          end
        end
        StIfAcc: begin
          if (bus_io.if_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (cnt_zero) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            // A flush seen in any access cycle, including this last one, drops the result.
            if (!(flush_pend_q || bus_io.if_flush)) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus_io.sram_rdata;
            end
          end
        end
        StMemAcc: begin
          if (cnt_zero) begin
            state_q      <= StIdle;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            mem_ready_q  <= 1'b1;
            if (!sram_we_q) begin
              mem_rdata_q <= bus_io.sram_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.sram_en    = sram_en_q;
  assign bus_io.sram_we    = sram_we_q;
  assign bus_io.sram_addr  = sram_addr_q;
  assign bus_io.sram_wdata = sram_wdata_q;
  assign bus_io.if_ready   = if_ready_q;
  assign bus_io.if_rdata   = if_rdata_q;
  assign bus_io.mem_ready  = mem_ready_q;
  assign bus_io.mem_rdata  = mem_rdata_q;
  assign bus_io.freeze     = (bus_io.if_req & ~if_ready_q) | (bus_io.mem_req & ~mem_ready_q);

endmodule
